lsu_mem_port: RTL and testbench
===============================

# lsu_mem_port

Load/store initiator for the single-port, byte-enabled data memory of the 64-bit core. Accepts one load or store request at a time from the execute stage and drives the memory's address, write data and byte-enable lanes. Splits misaligned accesses into two aligned beats and returns zero- or sign-extended load data through a valid-pulse response. Sits between the pipeline's memory stage and the data memory.

## Interface
- DATA_WIDTH, 64, memory and register data width
- ADDR_WIDTH, DATA_WIDTH, address width
- DATA_BYTES, DATA_WIDTH/8, byte lanes (8)
- SPLIT_MISALIGNED, 1, 1 = split line-crossing accesses into two beats; 0 = reject them without memory access
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  high only in IDLE; request accepted when valid && ready
- i_req_we  in  1  1 = store, 0 = load
- i_req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double
- i_req_unsigned  in  1  zero-extend load (LBU/LHU/LWU); ignored for size 3 and for stores
- i_req_addr  in  ADDR_WIDTH  byte address
- i_req_wdata  in  DATA_WIDTH  store data, right-justified
- o_resp_valid  out  1  one-cycle response pulse, loads and stores
- o_resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and rejects
- o_resp_misaligned  out  1  access crossed an 8-byte boundary
- o_mem_addr  out  ADDR_WIDTH  byte address to memory, always 8-byte aligned
- o_mem_wdata  out  DATA_WIDTH  lane-positioned write data
- o_mem_wen  out  DATA_BYTES  per-byte write enables
- i_mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after o_mem_addr is presented

## Operation
- Request fields are latched only on accept; any later change to the inputs is ignored. Valid without ready is ignored, and the requester holds the request until it is accepted.
- Definitions: off = addr[2:0]; nb = 1<<size; mask = (1<<nb)-1; split = off+nb > 8; base = addr with [2:0] cleared.
- States are IDLE, ACC0, ACC1, DONE.
  - IDLE -> ACC0 on accept. If split and SPLIT_MISALIGNED=0, go IDLE -> DONE instead.
  - ACC0 -> ACC1 if split, else ACC0 -> DONE.
  - ACC1 -> DONE.
  - DONE -> IDLE.
- ACC0 drives:
  - o_mem_addr = base
  - o_mem_wen = we ? (mask<<off)[7:0] : 0
  - o_mem_wdata = wdata<<(8*off)
- ACC1 drives:
  - o_mem_addr = base+8
  - o_mem_wen = we ? mask>>(8-off) : 0
  - o_mem_wdata = wdata>>(8*(8-off))
  - ACC1 also registers i_mem_rdata as beat0.
- Outside ACC0/ACC1, the memory outputs are combinationally 0: o_mem_addr = 0, o_mem_wen = 0, o_mem_wdata = 0.
- Load assembly, computed in DATA_WIDTH bits:
  - Non-split: raw = i_mem_rdata>>(8*off).
  - Split: raw = (beat0>>(8*off)) | (i_mem_rdata<<(8*(8-off))).
  - Truncate raw to 8*nb bits. Sign-extend from bit 8*nb-1 unless unsigned or size=3.
- At the DONE->IDLE edge the block registers:
  - o_resp_valid = 1
  - o_resp_rdata = we||rejected ? 0 : assembled value
  - o_resp_misaligned = split
- The response outputs clear on the next edge unless a new response is produced.
- Reset values: state = IDLE, o_resp_valid = 0, o_resp_rdata = 0, o_resp_misaligned = 0, beat0 = 0.

## Timing
- The accept cycle is cycle 0.
- Aligned access: ACC0 in cycle 1, DONE in cycle 2, o_resp_valid in cycle 3.
- Split access: ACC0 in cycle 1, ACC1 in cycle 2, DONE in cycle 3, o_resp_valid in cycle 4.
- Rejected access: DONE in cycle 1, o_resp_valid in cycle 2. No memory write occurs.
- o_req_ready is high in the cycle o_resp_valid is high, so a new request can be accepted in the same cycle as a response (back-to-back).
- Memory writes commit at the end of the ACC cycle that drives them.
- Reset mid-operation: state returns to IDLE immediately and o_mem_wen drops to 0 combinationally. A committed first beat of a split store is not rolled back. No response is produced.

## Test plan
- SD 0x0123456789ABCDEF @0x100, then LD @0x100:
  - SD drives wen = 0xFF at addr 0x100.
  - LD responds 0x0123456789ABCDEF in cycle 3 with misaligned = 0.
- SB 0x80 @0x103:
  - SB drives wen = 0x08.
  - LB @0x103 responds 0xFFFFFFFFFFFFFF80; LBU @0x103 responds 0x80.
- SW 0xDEADBEEF @0x10E (split):
  - Beat 0: addr 0x108, wen 0xC0, wdata[63:48] = 0xBEEF.
  - Beat 1: addr 0x110, wen 0x03, wdata[15:0] = 0xDEAD.
  - LW @0x10E responds 0xFFFFFFFFDEADBEEF in cycle 4 with misaligned = 1.
- SPLIT_MISALIGNED=0, LH @0x107 -> no nonzero wen and o_mem_addr stays 0; response in cycle 2 with rdata = 0 and misaligned = 1.
- Reset during ACC1 of SD 0x1122334455667788 @0x0FC:
  - Bytes 0x100..0x103 stay unchanged.
  - o_req_ready = 1 after reset release; no o_resp_valid pulse.
- Back-to-back: i_req_valid held high with SB 'A' (0x41) @0x40 then LD @0x100:
  - Second request is accepted in the same cycle as the first response.
  - Memory console prints 'A'.

Source files
------------

// File: rtl/lsu_mem_port.sv
// Load/store initiator for the byte-enabled single-port data memory.
// Misaligned accesses that cross a line become two aligned beats; loads return extended data.
module lsu_mem_port #(
  parameter int DATA_WIDTH       = 64,
  parameter int ADDR_WIDTH       = DATA_WIDTH,
  parameter int DATA_BYTES       = DATA_WIDTH / 8,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_resp_valid,
  output logic [DATA_WIDTH-1:0] o_resp_rdata,
  output logic                  o_resp_misaligned,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [DATA_BYTES-1:0] o_mem_wen,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam int OFF_W  = $clog2(DATA_BYTES);
  localparam int SUM_W  = OFF_W + 2;
  localparam int SH_W   = $clog2(DATA_WIDTH) + 1;
  localparam int MASK_W = 2 * DATA_BYTES;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  state_t state, state_nxt;

  logic                  we_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  split_q;
  logic                  rej_q;
  logic [DATA_WIDTH-1:0] beat0;

  logic                  accept;
  logic [OFF_W-1:0]      off_in;
  logic [OFF_W:0]        nb_in;
  logic                  split_in;

  logic [OFF_W-1:0]      off_q;
  logic [OFF_W:0]        nb_q;
  logic [OFF_W:0]        rem_q;
  logic [MASK_W-1:0]     mask_q;
  logic [DATA_BYTES-1:0] wen0, wen1;
  logic [SH_W-1:0]       sh0, sh1;
  logic [ADDR_WIDTH-1:0] base;
  logic [DATA_WIDTH-1:0] raw, ext;

  assign o_req_ready = (state == IDLE);
  assign accept      = i_req_valid && o_req_ready;

  assign off_in   = i_req_addr[OFF_W-1:0];
  assign nb_in    = (OFF_W+1)'(1) << i_req_size;
  assign split_in = (SUM_W'(off_in) + SUM_W'(nb_in)) > SUM_W'(DATA_BYTES);

  assign off_q  = addr_q[OFF_W-1:0];
  assign nb_q   = (OFF_W+1)'(1) << size_q;
  assign rem_q  = (OFF_W+1)'(DATA_BYTES) - (OFF_W+1)'(off_q);
  assign mask_q = (MASK_W'(1) << nb_q) - MASK_W'(1);
  assign wen0   = DATA_BYTES'(mask_q << off_q);
  assign wen1   = DATA_BYTES'(mask_q >> rem_q);
  assign sh0    = SH_W'(off_q) << 3;
  assign sh1    = SH_W'(DATA_WIDTH) - sh0;
  assign base   = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

  always_comb begin
    state_nxt   = state;
    o_mem_addr  = '0;
    o_mem_wen   = '0;
    o_mem_wdata = '0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (split_in && !SPLIT_MISALIGNED) ? DONE : ACC0;
      end
      ACC0: begin
        o_mem_addr  = base;
        o_mem_wen   = we_q ? wen0 : '0;
        o_mem_wdata = wdata_q << sh0;
        state_nxt   = split_q ? ACC1 : DONE;
      end
      ACC1: begin
        o_mem_addr  = base + ADDR_WIDTH'(DATA_BYTES);
        o_mem_wen   = we_q ? wen1 : '0;
        o_mem_wdata = wdata_q >> sh1;
        state_nxt   = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // In DONE, i_mem_rdata holds the last beat read (first line when aligned, second when split).
  always_comb begin
    raw = split_q ? ((beat0 >> sh0) | (i_mem_rdata << sh1)) : (i_mem_rdata >> sh0);
    case (size_q)
      2'd0:    ext = uns_q ? DATA_WIDTH'(raw[7:0])
                           : {{(DATA_WIDTH-8){raw[7]}}, raw[7:0]};
      2'd1:    ext = uns_q ? DATA_WIDTH'(raw[15:0])
                           : {{(DATA_WIDTH-16){raw[15]}}, raw[15:0]};
      2'd2:    ext = uns_q ? DATA_WIDTH'(raw[31:0])
                           : {{(DATA_WIDTH-32){raw[31]}}, raw[31:0]};
      default: ext = raw;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      we_q              <= 1'b0;
      size_q            <= '0;
      uns_q             <= 1'b0;
      addr_q            <= '0;
      wdata_q           <= '0;
      split_q           <= 1'b0;
      rej_q             <= 1'b0;
      beat0             <= '0;
      o_resp_valid      <= 1'b0;
      o_resp_rdata      <= '0;
      o_resp_misaligned <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q    <= i_req_we;
        size_q  <= i_req_size;
        uns_q   <= i_req_unsigned;
        addr_q  <= i_req_addr;
        wdata_q <= i_req_wdata;
        split_q <= split_in;
        rej_q   <= split_in && !SPLIT_MISALIGNED;
      end
      if (state == ACC1) beat0 <= i_mem_rdata;
      o_resp_valid      <= (state == DONE);
      o_resp_rdata      <= (state == DONE && !we_q && !rej_q) ? ext : '0;
      o_resp_misaligned <= (state == DONE) && split_q;
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: byte-lane memory model, a splitting instance
// and a rejecting instance, with hand-computed expected values.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 0, req_we = 0, req_uns = 0;
  logic [1:0]  req_size = 0;
  logic [63:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, resp_valid, resp_mis;
  logic [63:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wen;

  logic        b_valid = 0, b_we = 0, b_uns = 0;
  logic [1:0]  b_size = 0;
  logic [63:0] b_addr_in = 0, b_wdata_in = 0;
  logic        b_ready, b_resp_valid, b_resp_mis;
  logic [63:0] b_resp_rdata, b_mem_addr, b_mem_wdata;
  logic [63:0] b_mem_rdata = 64'h0;
  logic [7:0]  b_mem_wen;

  lsu_mem_port #(.SPLIT_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_size(req_size), .i_req_unsigned(req_uns), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata),
    .o_resp_misaligned(resp_mis), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_wen(mem_wen), .i_mem_rdata(mem_rdata)
  );

  lsu_mem_port #(.SPLIT_MISALIGNED(1'b0)) dut_rej (
    .clk(clk), .rst(rst),
    .i_req_valid(b_valid), .o_req_ready(b_ready), .i_req_we(b_we),
    .i_req_size(b_size), .i_req_unsigned(b_uns), .i_req_addr(b_addr_in),
    .i_req_wdata(b_wdata_in), .o_resp_valid(b_resp_valid), .o_resp_rdata(b_resp_rdata),
    .o_resp_misaligned(b_resp_mis), .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata),
    .o_mem_wen(b_mem_wen), .i_mem_rdata(b_mem_rdata)
  );

  // Byte-lane memory: registered read, per-lane write, console byte at 0x40.
  logic [7:0] mem [0:511];
  logic [7:0] console = 8'h00;
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      mem_rdata[8*i +: 8] <= mem[{mem_addr[8:3], 3'(i)}];
      if (mem_wen[i]) mem[{mem_addr[8:3], 3'(i)}] <= mem_wdata[8*i +: 8];
    end
    if (mem_wen[0] && mem_addr == 64'h40) begin
      console <= mem_wdata[7:0];
      $display("console: %c", mem_wdata[7:0]);
    end
  end

  int n_cmp = 0, n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int          lat;
  logic [63:0] rsp_data;
  logic        rsp_mis;
  logic [63:0] cyc_addr  [0:15];
  logic [63:0] cyc_wdata [0:15];
  logic [7:0]  cyc_wen   [0:15];

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata);
    @(negedge clk);
    req_valid = 1; req_we = we; req_size = size; req_uns = uns;
    req_addr = addr; req_wdata = wdata;
    chk("ready_before_accept", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 0;
    lat = 0; rsp_data = 'x; rsp_mis = 1'bx;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      cyc_addr[k] = mem_addr; cyc_wen[k] = mem_wen; cyc_wdata[k] = mem_wdata;
      if (resp_valid) begin
        lat = k; rsp_data = resp_rdata; rsp_mis = resp_mis;
        break;
      end
    end
  endtask

  int   k1, k2;
  logic seen;
  logic [63:0] acc_addr;
  logic [7:0]  acc_wen;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_mis", resp_mis, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst = 0;

    // SD then LD, aligned
    do_req(1, 2'd3, 0, 64'h100, 64'h0123456789ABCDEF);
    chk("sd_lat", lat, 3);
    chk("sd_addr", cyc_addr[1], 64'h100);
    chk("sd_wen", cyc_wen[1], 8'hFF);
    chk("sd_wdata", cyc_wdata[1], 64'h0123456789ABCDEF);
    chk("sd_rdata", rsp_data, 0);
    do_req(0, 2'd3, 0, 64'h100, 64'h0);
    chk("ld_lat", lat, 3);
    chk("ld_rdata", rsp_data, 64'h0123456789ABCDEF);
    chk("ld_mis", rsp_mis, 0);

    // byte store and signed/unsigned byte loads
    do_req(1, 2'd0, 0, 64'h103, 64'h80);
    chk("sb_wen", cyc_wen[1], 8'h08);
    chk("sb_wdata_lane", cyc_wdata[1][31:24], 8'h80);
    do_req(0, 2'd0, 0, 64'h103, 64'h0);
    chk("lb_rdata", rsp_data, 64'hFFFFFFFFFFFFFF80);
    do_req(0, 2'd0, 1, 64'h103, 64'h0);
    chk("lbu_rdata", rsp_data, 64'h80);
    do_req(0, 2'd1, 1, 64'h102, 64'h0);
    chk("lhu_rdata", rsp_data, 64'h80AB);
    do_req(0, 2'd1, 0, 64'h102, 64'h0);
    chk("lh_rdata", rsp_data, 64'hFFFFFFFFFFFF80AB);

    // split word store / load
    do_req(1, 2'd2, 0, 64'h10E, 64'hDEADBEEF);
    chk("sw_lat", lat, 4);
    chk("sw_b0_addr", cyc_addr[1], 64'h108);
    chk("sw_b0_wen", cyc_wen[1], 8'hC0);
    chk("sw_b0_wdata", cyc_wdata[1][63:48], 16'hBEEF);
    chk("sw_b1_addr", cyc_addr[2], 64'h110);
    chk("sw_b1_wen", cyc_wen[2], 8'h03);
    chk("sw_b1_wdata", cyc_wdata[2][15:0], 16'hDEAD);
    chk("sw_mis", rsp_mis, 1);
    do_req(0, 2'd2, 0, 64'h10E, 64'h0);
    chk("lw_split_lat", lat, 4);
    chk("lw_split_rdata", rsp_data, 64'hFFFFFFFFDEADBEEF);
    chk("lw_split_mis", rsp_mis, 1);
    do_req(0, 2'd2, 1, 64'h10E, 64'h0);
    chk("lwu_split_rdata", rsp_data, 64'hDEADBEEF);

    // rejecting instance: LH @0x107
    @(negedge clk);
    b_valid = 1; b_we = 0; b_size = 2'd1; b_uns = 0; b_addr_in = 64'h107;
    chk("rej_ready", b_ready, 1);
    @(posedge clk);
    #1 b_valid = 0;
    k1 = 0; acc_addr = 0; acc_wen = 0;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      acc_addr = acc_addr | b_mem_addr;
      acc_wen  = acc_wen | b_mem_wen;
      if (b_resp_valid) begin
        k1 = k; chk("rej_rdata", b_resp_rdata, 0); chk("rej_mis", b_resp_mis, 1);
        break;
      end
    end
    chk("rej_lat", k1, 2);
    chk("rej_wen", acc_wen, 0);
    chk("rej_addr", acc_addr, 0);

    // reset during ACC1 of a split SD @0x0FC
    @(negedge clk);
    req_valid = 1; req_we = 1; req_size = 2'd3; req_uns = 0;
    req_addr = 64'hFC; req_wdata = 64'h1122334455667788;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    chk("rsd_b0_wen", mem_wen, 8'hF0);
    chk("rsd_b0_addr", mem_addr, 64'hF8);
    @(negedge clk);
    chk("rsd_b1_wen", mem_wen, 8'h0F);
    rst = 1;
    #1;
    chk("rsd_wen_drop", mem_wen, 0);
    chk("rsd_ready_in_rst", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
    end
    chk("rsd_ready_after", req_ready, 1);
    chk("rsd_no_resp", seen, 0);
    chk("rsd_second_line", {mem[259], mem[258], mem[257], mem[256]}, 32'h80ABCDEF);
    chk("rsd_first_line", {mem[255], mem[254], mem[253], mem[252]}, 32'h55667788);

    // back-to-back: SB 'A' @0x40, then LD @0x100 with valid held
    @(negedge clk);
    req_valid = 1; req_we = 1; req_size = 2'd0; req_uns = 0;
    req_addr = 64'h40; req_wdata = 64'h41;
    @(posedge clk);
    #1 req_we = 0; req_size = 2'd3; req_addr = 64'h100; req_wdata = 64'h0;
    k1 = 0;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        k1 = k;
        chk("b2b_ready_with_resp", req_ready, 1);
        chk("b2b_sb_rdata", resp_rdata, 0);
        break;
      end
    end
    chk("b2b_first_lat", k1, 3);
    @(posedge clk);
    #1 req_valid = 0;
    k2 = 0;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        k2 = k;
        chk("b2b_ld_rdata", resp_rdata, 64'h0123456780ABCDEF);
        break;
      end
    end
    chk("b2b_second_lat", k2, 3);
    chk("b2b_console", console, 8'h41);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
